// File: rtl/simon_seq_engine.sv
`timescale 1ns/1ps
// simon_seq_engine
// Sequence datapath for the Simon game: stores the player-built sequence,
// compares switch input against it, and plays the whole stored sequence back
// on the LEDs on request from the control FSM (play_start / play_done).
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   level, load_level      level switch and its capture strobe
//   pattern                switch inputs (WIDTH lanes)
//   count_clr, count_cnt   clear / increment stored sequence length
//   index_clr, index_cnt   clear / increment compare index (wraps)
//   write_en               store pattern at mem[count]
//   disp_mem               show mem[index] on LEDs when not playing
//   play_start             request playback of entries 0..count-1
//   index_lt_count         index < count
//   pattern_eq_mem         pattern == mem[index]
//   pattern_valid          one-hot pattern, or level_reg set
//   count_full             count == DEPTH
//   play_busy, play_done   playback in progress / one-cycle end pulse
//   pattern_leds           LED drive
//
// Playback FSM
//   state | meaning
//   IDLE  | controls accepted, LEDs show pattern or mem[index]
//   SHOW  | LEDs show mem[ptr] for HOLD cycles
//   GAP   | LEDs blank for GAP cycles, then next entry or DONE
//   DONE  | play_done pulse, back to IDLE
module simon_seq_engine #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level,
  input  logic [WIDTH-1:0] pattern,
  input  logic             count_clr,
  input  logic             count_cnt,
  input  logic             index_clr,
  input  logic             index_cnt,
  input  logic             write_en,
  input  logic             load_level,
  input  logic             disp_mem,
  input  logic             play_start,
  output logic             index_lt_count,
  output logic             pattern_eq_mem,
  output logic             pattern_valid,
  output logic             count_full,
  output logic             play_busy,
  output logic             play_done,
  output logic [WIDTH-1:0] pattern_leds
);

  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD - 1);
  localparam logic [TW-1:0]    GAP_LD  = TW'(GAP - 1);
  localparam logic [TW-1:0]    TMR_ONE = TW'(1);
  localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]      FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    IDX_ONE = AW'(1);
  localparam logic [WIDTH-1:0] PAT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      count_q;
  logic [AW-1:0]    index_q;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             level_q;
  logic             ctl_open;
  logic             wr_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  // Sequence-building controls are frozen from playback start through DONE.
  assign ctl_open = (state_q == ST_IDLE);
  assign count_full = (count_q == FULL_C);
  assign wr_ok = rst && write_en && !count_full && ctl_open;

  // Memory has no reset; the write address is the pre-increment count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[count_q[AW-1:0]] <= pattern;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      index_q <= '0;
      level_q <= 1'b0;
    end else begin
      if (ctl_open) begin
        if (count_clr)                    count_q <= '0;
        else if (count_cnt && !count_full) count_q <= count_q + CNT_ONE;
      end
      // DEPTH is 2**AW, so the index wraps naturally.
      if (index_clr)      index_q <= '0;
      else if (index_cnt) index_q <= index_q + IDX_ONE;
      if (load_level) level_q <= level;
    end
  end

  assign index_lt_count = ({1'b0, index_q} < count_q);
  assign pattern_eq_mem = (pattern == mem[index_q]);
  // One-hot test: nonzero with no bit left after clearing the lowest set bit.
  assign pattern_valid  = ((pattern != '0) && ((pattern & (pattern - PAT_ONE)) == '0))
                          || level_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    play_busy    = 1'b0;
    play_done    = 1'b0;
    pattern_leds = disp_mem ? mem[index_q] : pattern;
    case (state_q)
      ST_IDLE: begin
        if (play_start) begin
          if (count_q != '0) begin
            ptr_d   = '0;
            timer_d = HOLD_LD;
            state_d = ST_SHOW;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHOW: begin
        play_busy    = 1'b1;
        pattern_leds = mem[ptr_q];
        if (timer_q == '0) begin
          timer_d = GAP_LD;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_GAP: begin
        play_busy    = 1'b1;
        pattern_leds = '0;
        if (timer_q == '0) begin
          if ({1'b0, ptr_q} == count_q - CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            ptr_d   = ptr_q + IDX_ONE;
            timer_d = HOLD_LD;
            state_d = ST_SHOW;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      ST_DONE: begin
        play_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
`timescale 1ns/1ps
// Bench for simon_seq_engine: a reference model tracks count/index/level/memory
// and expands each accepted playback into a per-cycle schedule of LED values;
// a negedge process compares all outputs against it every cycle, and the
// stimulus adds literal expectations for the key scenarios.
module tb_simon_seq_engine;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             level;
  logic [WIDTH-1:0] pattern;
  logic             count_clr, count_cnt, index_clr, index_cnt;
  logic             write_en, load_level, disp_mem, play_start;
  logic             index_lt_count, pattern_eq_mem, pattern_valid, count_full;
  logic             play_busy, play_done;
  logic [WIDTH-1:0] pattern_leds;

  simon_seq_engine #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .HOLD(HOLD), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern),
    .count_clr(count_clr), .count_cnt(count_cnt),
    .index_clr(index_clr), .index_cnt(index_cnt),
    .write_en(write_en), .load_level(load_level), .disp_mem(disp_mem),
    .play_start(play_start),
    .index_lt_count(index_lt_count), .pattern_eq_mem(pattern_eq_mem),
    .pattern_valid(pattern_valid), .count_full(count_full),
    .play_busy(play_busy), .play_done(play_done), .pattern_leds(pattern_leds)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit             done;
    logic [WIDTH-1:0] leds;
  } slot_t;

  slot_t            sched[$];
  slot_t            cur;
  bit               active = 0;
  bit               m_init = 0;
  int               m_count, m_index;
  bit               m_level;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_known [DEPTH];

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_count = 0;
      m_index = 0;
      m_level = 0;
      sched.delete();
      active = 0;
      m_init = 1;
    end else if (m_init) begin
      bit blocked;
      blocked = active;
      if (!blocked && play_start) begin
        for (int k = 0; k < m_count; k++) begin
          for (int h = 0; h < HOLD; h++) sched.push_back('{done: 1'b0, leds: m_mem[k]});
          for (int g = 0; g < GAP; g++)  sched.push_back('{done: 1'b0, leds: '0});
        end
        sched.push_back('{done: 1'b1, leds: '0});
      end
      if (!blocked) begin
        if (write_en && m_count != DEPTH) begin
          m_mem[m_count]   = pattern;
          m_known[m_count] = 1;
        end
        if (count_clr) m_count = 0;
        else if (count_cnt && m_count != DEPTH) m_count = m_count + 1;
      end
      if (index_clr) m_index = 0;
      else if (index_cnt) m_index = (m_index + 1) % DEPTH;
      if (load_level) m_level = level;
      if (sched.size() > 0) begin
        cur    = sched.pop_front();
        active = 1;
      end else begin
        active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [WIDTH-1:0] exp_leds;
      bit               leds_known;
      chk("index_lt_count", index_lt_count, m_index < m_count);
      if (m_known[m_index]) chk("pattern_eq_mem", pattern_eq_mem, pattern == m_mem[m_index]);
      chk("pattern_valid", pattern_valid, ($countones(pattern) == 1) || m_level);
      chk("count_full", count_full, m_count == DEPTH);
      chk("play_busy", play_busy, active && !cur.done);
      chk("play_done", play_done, active && cur.done);
      if (active && !cur.done) begin
        exp_leds = cur.leds; leds_known = 1;
      end else if (disp_mem) begin
        exp_leds = m_mem[m_index]; leds_known = m_known[m_index];
      end else begin
        exp_leds = pattern; leds_known = 1;
      end
      if (leds_known) chk("pattern_leds", pattern_leds, exp_leds);
    end
  end

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] play_seq [9] = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd0, 4'd4, 4'd4, 4'd0};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] v);
    pattern = v; write_en = 1; count_cnt = 1;
    cyc();
    write_en = 0; count_cnt = 0;
  endtask

  initial begin
    rst = 0; level = 0; pattern = 4'b1010;
    count_clr = 0; count_cnt = 0; index_clr = 0; index_cnt = 0;
    write_en = 0; load_level = 0; disp_mem = 0; play_start = 0;
    cyc(); cyc();
    chk("rst_lt", index_lt_count, 1'b0);
    chk("rst_full", count_full, 1'b0);
    chk("rst_busy", play_busy, 1'b0);
    chk("rst_done", play_done, 1'b0);
    chk("rst_leds", pattern_leds, 4'b1010);
    rst = 1;

    wr(4'd1); wr(4'd2); wr(4'd4); wr(4'd8);
    chk("wr4_lt", index_lt_count, 1'b1);
    chk("wr4_full", count_full, 1'b0);
    disp_mem = 1; pattern = 4'd0;
    cyc();
    chk("mem0_leds", pattern_leds, 4'd1);

    index_cnt = 1; cyc(); cyc(); index_cnt = 0;
    pattern = 4'b0100; cyc();
    chk("eq_idx2", pattern_eq_mem, 1'b1);
    chk("valid_onehot", pattern_valid, 1'b1);
    chk("mem2_leds", pattern_leds, 4'd4);
    index_cnt = 1; cyc(); cyc(); index_cnt = 0; cyc();
    chk("lt_idx4", index_lt_count, 1'b0);

    pattern = 4'b0110; cyc();
    chk("valid_twohot", pattern_valid, 1'b0);
    level = 1; load_level = 1; cyc(); load_level = 0; level = 0;
    chk("valid_level", pattern_valid, 1'b1);
    load_level = 1; cyc(); load_level = 0;
    chk("valid_level_clr", pattern_valid, 1'b0);

    wr(4'd3); wr(4'd5); wr(4'd6); wr(4'd9);
    chk("full8", count_full, 1'b1);
    wr(4'd15);
    chk("full_stays", count_full, 1'b1);
    index_clr = 1; cyc(); index_clr = 0;
    chk("mem0_kept", pattern_leds, 4'd1);
    index_cnt = 1;
    for (int i = 0; i < 7; i++) cyc();
    chk("mem7_leds", pattern_leds, 4'd9);
    cyc(); index_cnt = 0;
    chk("idx_wrap", pattern_leds, 4'd1);

    count_clr = 1; count_cnt = 1; cyc(); count_clr = 0; count_cnt = 0;
    chk("clr_pri_full", count_full, 1'b0);
    chk("clr_pri_lt", index_lt_count, 1'b0);

    disp_mem = 0;
    wr(4'd1); wr(4'd2); wr(4'd4);
    pattern = 4'b1000; play_start = 1; cyc(); play_start = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 9) chk("play_leds", pattern_leds, play_seq[c-1]);
      else chk("play_leds_idle", pattern_leds, 4'b1000);
      chk("play_busy_t", play_busy, c <= 9);
      chk("play_done_t", play_done, c == 10);
      if (c == 3) begin write_en = 1; count_cnt = 1; end
      if (c == 6) begin write_en = 0; count_cnt = 0; end
      play_start = (c == 10);
      cyc();
    end
    play_start = 0;
    index_cnt = 1; cyc(); cyc(); cyc(); index_cnt = 0;
    chk("count_kept3", index_lt_count, 1'b0);

    count_clr = 1; cyc(); count_clr = 0;
    play_start = 1; cyc(); play_start = 0;
    chk("empty_done", play_done, 1'b1);
    chk("empty_busy", play_busy, 1'b0);
    cyc();
    chk("empty_done_end", play_done, 1'b0);
    chk("empty_busy_end", play_busy, 1'b0);

    index_clr = 1; cyc(); index_clr = 0;
    wr(4'd1); wr(4'd2);
    play_start = 1; cyc(); play_start = 0;
    cyc();
    chk("abort_busy_pre", play_busy, 1'b1);
    rst = 0; pattern = 4'b0101; cyc(); rst = 1;
    chk("abort_busy", play_busy, 1'b0);
    chk("abort_done", play_done, 1'b0);
    chk("abort_lt", index_lt_count, 1'b0);
    chk("abort_leds", pattern_leds, 4'b0101);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("abort_no_done", play_done, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
